// File: rtl/snake_pkg.sv
// Shared types and helpers for the snake control and drawing stages.
// Direction codes, game-state codes, reversal lookup and button priority decode.
package snake_pkg;

    typedef enum logic [2:0] {
        DIR_IDLE  = 3'b000,
        DIR_UP    = 3'b001,
        DIR_DOWN  = 3'b010,
        DIR_LEFT  = 3'b011,
        DIR_RIGHT = 3'b100
    } dir_t;

    // Only PLAY is acted on; every other code means "not playing".
    typedef enum logic [1:0] {
        GS_PLAY      = 2'b01,
        GS_GAME_OVER = 2'b11
    } game_state_t;

    // The direction that would make the snake turn back onto itself.
    function automatic dir_t opposite(input dir_t d);
        case (d)
            DIR_UP:    return DIR_DOWN;
            DIR_DOWN:  return DIR_UP;
            DIR_LEFT:  return DIR_RIGHT;
            DIR_RIGHT: return DIR_LEFT;
            default:   return DIR_IDLE;
        endcase
    endfunction

    // Several held buttons resolve as UP > DOWN > LEFT > RIGHT.
    function automatic dir_t decode_request(input logic up, input logic down,
                                            input logic left, input logic right);
        if (up)    return DIR_UP;
        if (down)  return DIR_DOWN;
        if (left)  return DIR_LEFT;
        if (right) return DIR_RIGHT;
        return DIR_IDLE;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser followed by a stability counter for one raw button.
// The filtered level flips only after the synchronised input has disagreed
// with it for DEBOUNCE_CYCLES consecutive clocks (DEBOUNCE_CYCLES+2 from a raw edge).
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic level
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] count;

    // Bring the asynchronous button into the clk domain.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            // NOTE: non-blocking so sync1 and sync2 stay two distinct stages;
            // blocking here would collapse the chain into a single flop.
            sync1 <= btn;
            sync2 <= sync1;
        end
    end

    // Count consecutive disagreeing samples; any agreeing sample restarts the count.
    always_ff @(posedge clk) begin
        if (reset) begin
            level <= 1'b0;
            count <= '0;
        end else if (sync2 != level) begin
            if (count == CW'(DEBOUNCE_CYCLES - 1)) begin
                level <= ~level;
                count <= '0;
            end else begin
                count <= count + 1'b1;
            end
        end else begin
            count <= '0;
        end
    end

endmodule

// File: rtl/snake_control.sv
// Snake control: debounced buttons -> direction code plus one-clock move strobe.
// Optional feature macro SNAKE_SPEEDUP_EN: each grow pulse in PLAY shortens the
// move period by one frame down to MIN_PERIOD; leaving PLAY restores MOVE_PERIOD.
// Without the macro, grow is ignored and the period is fixed at MOVE_PERIOD.
module snake_control
    import snake_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int MOVE_PERIOD     = 6,
    parameter int MIN_PERIOD      = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       frame_tick,
    input  logic [1:0] game_state,
    input  logic       grow,
    output logic [2:0] direction,
    output logic       update
);

    localparam int PW = $clog2(MOVE_PERIOD + 1);

    logic          lvl_up, lvl_down, lvl_left, lvl_right;
    dir_t          request;
    dir_t          dir_q;
    dir_t          pending_q;
    dir_t          dir_after;
    logic          accept;
    logic          play;
    logic          due;
    logic [PW-1:0] count_q;
    logic [PW-1:0] period;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
        .clk(clk), .reset(reset), .btn(btn_up), .level(lvl_up)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_down (
        .clk(clk), .reset(reset), .btn(btn_down), .level(lvl_down)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_left (
        .clk(clk), .reset(reset), .btn(btn_left), .level(lvl_left)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_right (
        .clk(clk), .reset(reset), .btn(btn_right), .level(lvl_right)
    );

    assign request = decode_request(lvl_up, lvl_down, lvl_left, lvl_right);
    assign play    = (game_state == GS_PLAY);

    // ">=" rather than "==" so a period shortened mid-interval can never
    // leave the counter stranded above the new compare value.
    assign due = play && frame_tick && (count_q >= (period - 1'b1));

    // Reversal check is made against the direction that will be committed
    // after this edge, so a request arriving with an update is judged
    // against the newly committed direction, never against pending.
    assign dir_after = due ? pending_q : dir_q;
    assign accept    = (request != DIR_IDLE) &&
                       ((dir_after == DIR_IDLE) || (request != opposite(dir_after)));

`ifdef SNAKE_SPEEDUP_EN
    // Shorten the move period on each grow in PLAY; restore it outside PLAY.
    always_ff @(posedge clk) begin
        if (reset || !play) begin
            period <= PW'(MOVE_PERIOD);
        end else if (grow && (int'(period) > MIN_PERIOD)) begin
            period <= period - 1'b1;
        end
    end
`else
    logic unused_cfg;
    assign period     = PW'(MOVE_PERIOD);
    assign unused_cfg = grow ^ (MIN_PERIOD > 0);
`endif

    // Frame pacing, direction commit and pending-request capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: every register here takes a reset value; there is no
            // memory array in this block, so nothing is left unknown.
            dir_q     <= DIR_IDLE;
            pending_q <= DIR_IDLE;
            count_q   <= '0;
            update    <= 1'b0;
        end else if (!play) begin
            dir_q     <= DIR_IDLE;
            pending_q <= DIR_IDLE;
            count_q   <= '0;
            update    <= 1'b0;
        end else begin
            update <= due;
            if (due) begin
                count_q <= '0;
                dir_q   <= pending_q;
            end else if (frame_tick) begin
                count_q <= count_q + 1'b1;
            end
            if (accept) begin
                pending_q <= request;
            end
        end
    end

    assign direction = dir_q;

endmodule
